// File: rtl/gtype.sv
// Shared types for the 10GBASE-R lane bring-up sequencer.
package gtype;

  // Width of the saturating attempt counter.
  localparam int RETRY_W = 8;

  typedef enum logic [2:0] {
    LS_PD        = 3'd0,
    LS_PLL_WAIT  = 3'd1,
    LS_XCVR_WAIT = 3'd2,
    LS_SYNC_WAIT = 3'd3,
    LS_LINK_UP   = 3'd4
  } link_state_t;

  // Control outputs driven towards the fPLL, the transceiver and the TX path.
  typedef struct packed {
    logic pll_powerdown;
    logic xcvr_rst;
    logic tx_en;
    logic link_up;
  } link_out_t;

  localparam link_out_t LINK_OUT_RST = '{
    pll_powerdown: 1'b1,
    xcvr_rst:      1'b1,
    tx_en:         1'b0,
    link_up:       1'b0
  };

  // Output pattern owned by each state; anything unknown looks like power-down.
  function automatic link_out_t decode_outputs(input link_state_t s);
    link_out_t o;
    o = LINK_OUT_RST;
    case (s)
      LS_PD:        o = LINK_OUT_RST;
      LS_PLL_WAIT:  o = '{pll_powerdown: 1'b0, xcvr_rst: 1'b1, tx_en: 1'b0, link_up: 1'b0};
      LS_XCVR_WAIT: o = '{pll_powerdown: 1'b0, xcvr_rst: 1'b0, tx_en: 1'b0, link_up: 1'b0};
      LS_SYNC_WAIT: o = '{pll_powerdown: 1'b0, xcvr_rst: 1'b0, tx_en: 1'b1, link_up: 1'b0};
      LS_LINK_UP:   o = '{pll_powerdown: 1'b0, xcvr_rst: 1'b0, tx_en: 1'b1, link_up: 1'b1};
      default:      o = LINK_OUT_RST;
    endcase
    return o;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so both stages sample their inputs at the
    // same edge; blocking ones would collapse the chain into a single flop.
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/link_ctrl.sv
// Bring-up and recovery sequencer for one 10GBASE-R lane: fPLL power-down,
// transceiver reset, PLL lock, transceiver ready and filtered PCS block sync.
module link_ctrl
  import gtype::*;
#(
  parameter int PD_CYCLES    = 16,
  parameter int PLL_TIMEOUT  = 4096,
  parameter int XCVR_TIMEOUT = 4096,
  parameter int SYNC_TIMEOUT = 65536,
  parameter int UP_HOLD      = 256,
  parameter int LOSS_FILTER  = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               force_down,
  input  logic               pll_locked,
  input  logic               pll_cal_busy,
  input  logic               xcvr_tx_rdy,
  input  logic               xcvr_rx_rdy,
  input  logic               rx_sync,
  output logic               pll_powerdown,
  output logic               xcvr_rst,
  output logic               tx_en,
  output logic               link_up,
  output logic [2:0]         state,
  output logic [RETRY_W-1:0] retry_cnt
);

  // One timer serves every state, so it is sized for the largest parameter.
  localparam int T_MAX = max_int(max_int(max_int(PD_CYCLES, PLL_TIMEOUT),
                                         max_int(XCVR_TIMEOUT, SYNC_TIMEOUT)),
                                 max_int(UP_HOLD, LOSS_FILTER));
  localparam int TW = $clog2(T_MAX) + 1;
  localparam int HW = $clog2(UP_HOLD) + 1;
  localparam int LW = $clog2(LOSS_FILTER) + 1;

  localparam logic [TW-1:0] PD_LAST   = TW'(PD_CYCLES - 1);
  localparam logic [TW-1:0] PLL_LAST  = TW'(PLL_TIMEOUT - 1);
  localparam logic [TW-1:0] XCVR_LAST = TW'(XCVR_TIMEOUT - 1);
  localparam logic [TW-1:0] SYNC_LAST = TW'(SYNC_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_DONE = HW'(UP_HOLD);
  localparam logic [LW-1:0] LOSS_DONE = LW'(LOSS_FILTER);

  // Synchronized status inputs.
  logic pll_locked_s;
  logic pll_cal_busy_s;
  logic xcvr_tx_rdy_s;
  logic xcvr_rx_rdy_s;
  logic rx_sync_s;

  sync_2ff u_sync_pll_locked (
    .clk (clk), .rst (rst), .d (pll_locked),   .q (pll_locked_s)
  );
  sync_2ff u_sync_pll_cal_busy (
    .clk (clk), .rst (rst), .d (pll_cal_busy), .q (pll_cal_busy_s)
  );
  sync_2ff u_sync_xcvr_tx_rdy (
    .clk (clk), .rst (rst), .d (xcvr_tx_rdy),  .q (xcvr_tx_rdy_s)
  );
  sync_2ff u_sync_xcvr_rx_rdy (
    .clk (clk), .rst (rst), .d (xcvr_rx_rdy),  .q (xcvr_rx_rdy_s)
  );
  sync_2ff u_sync_rx_sync (
    .clk (clk), .rst (rst), .d (rx_sync),      .q (rx_sync_s)
  );

  logic pll_ok;
  logic xcvr_ok;

  assign pll_ok  = pll_locked_s & ~pll_cal_busy_s;
  assign xcvr_ok = xcvr_tx_rdy_s & xcvr_rx_rdy_s;

  link_state_t   state_q;
  link_state_t   state_nxt;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_nxt;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_nxt;
  logic [LW-1:0] loss_q;
  logic [LW-1:0] loss_nxt;
  logic          retry_inc;
  logic          timer_clr;
  link_out_t     out_q;

  // Next-state, retry and filter-counter decisions, loss events first.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_nxt = state_q;
    retry_inc = 1'b0;
    timer_clr = 1'b0;
    hold_nxt  = '0;
    loss_nxt  = '0;

    case (state_q)
      LS_PD: begin
        // Holding force_down keeps the power-down window restarting.
        if (force_down) begin
          timer_clr = 1'b1;
        end else if (timer_q == PD_LAST) begin
          state_nxt = LS_PLL_WAIT;
        end
      end

      LS_PLL_WAIT: begin
        if (force_down) begin
          state_nxt = LS_PD;
        end else if (pll_ok) begin
          state_nxt = LS_XCVR_WAIT;
        end else if (timer_q == PLL_LAST) begin
          state_nxt = LS_PD;
          retry_inc = 1'b1;
        end
      end

      LS_XCVR_WAIT: begin
        if (force_down) begin
          state_nxt = LS_PD;
        end else if (!pll_locked_s) begin
          state_nxt = LS_PD;
          retry_inc = 1'b1;
        end else if (xcvr_ok) begin
          state_nxt = LS_SYNC_WAIT;
        end else if (timer_q == XCVR_LAST) begin
          state_nxt = LS_PD;
          retry_inc = 1'b1;
        end
      end

      LS_SYNC_WAIT: begin
        // Consecutive-sync run length; any gap starts it over.
        hold_nxt = rx_sync_s ? hold_q + 1'b1 : '0;
        if (force_down) begin
          state_nxt = LS_PD;
        end else if (!pll_locked_s || !xcvr_ok) begin
          state_nxt = LS_PD;
          retry_inc = 1'b1;
        end else if (hold_nxt == HOLD_DONE) begin
          state_nxt = LS_LINK_UP;
        end else if (timer_q == SYNC_LAST) begin
          state_nxt = LS_PD;
          retry_inc = 1'b1;
        end
      end

      LS_LINK_UP: begin
        // Consecutive-loss run length; short sync dropouts are ignored.
        loss_nxt = rx_sync_s ? '0 : loss_q + 1'b1;
        if (force_down) begin
          state_nxt = LS_PD;
        end else if (!pll_locked_s || !xcvr_ok) begin
          state_nxt = LS_PD;
          retry_inc = 1'b1;
        end else if (loss_nxt == LOSS_DONE) begin
          state_nxt = LS_SYNC_WAIT;
        end
      end

      default: begin
        state_nxt = LS_PD;
      end
    endcase

    // Every transition starts the new state with fresh counters.
    if (state_nxt != state_q) begin
      timer_clr = 1'b1;
      hold_nxt  = '0;
      loss_nxt  = '0;
    end

    if (timer_clr) begin
      timer_nxt = '0;
    end else if (timer_q == '1) begin
      timer_nxt = timer_q;
    end else begin
      timer_nxt = timer_q + 1'b1;
    end
  end

  // State, counters and outputs; outputs follow the next state so they move
  // together with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LS_PD;
      timer_q   <= '0;
      hold_q    <= '0;
      loss_q    <= '0;
      retry_cnt <= '0;
      out_q     <= LINK_OUT_RST;
    end else begin
      state_q <= state_nxt;
      timer_q <= timer_nxt;
      hold_q  <= hold_nxt;
      loss_q  <= loss_nxt;
      out_q   <= decode_outputs(state_nxt);
      if (retry_inc && (retry_cnt != '1)) begin
        retry_cnt <= retry_cnt + 1'b1;
      end
    end
  end

  assign state         = state_q;
  assign pll_powerdown = out_q.pll_powerdown;
  assign xcvr_rst      = out_q.xcvr_rst;
  assign tx_en         = out_q.tx_en;
  assign link_up       = out_q.link_up;

endmodule

// File: tb/tb_link_ctrl.sv
// Self-checking bench for link_ctrl with small timing parameters. Expected
// output snapshots are queued as stimulus is applied and popped when the DUT
// reaches the corresponding clock edge.
module tb_link_ctrl;
  import gtype::*;

  localparam int PD_CYCLES    = 4;
  localparam int PLL_TIMEOUT  = 32;
  localparam int XCVR_TIMEOUT = 32;
  localparam int SYNC_TIMEOUT = 128;
  localparam int UP_HOLD      = 8;
  localparam int LOSS_FILTER  = 4;

  logic         clk;
  logic         rst;
  logic         force_down;
  logic         pll_locked;
  logic         pll_cal_busy;
  logic         xcvr_tx_rdy;
  logic         xcvr_rx_rdy;
  logic         rx_sync;
  logic         pll_powerdown;
  logic         xcvr_rst;
  logic         tx_en;
  logic         link_up;
  logic [2:0]   state;
  logic [7:0]   retry_cnt;

  link_ctrl #(
    .PD_CYCLES    (PD_CYCLES),
    .PLL_TIMEOUT  (PLL_TIMEOUT),
    .XCVR_TIMEOUT (XCVR_TIMEOUT),
    .SYNC_TIMEOUT (SYNC_TIMEOUT),
    .UP_HOLD      (UP_HOLD),
    .LOSS_FILTER  (LOSS_FILTER)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .force_down    (force_down),
    .pll_locked    (pll_locked),
    .pll_cal_busy  (pll_cal_busy),
    .xcvr_tx_rdy   (xcvr_tx_rdy),
    .xcvr_rx_rdy   (xcvr_rx_rdy),
    .rx_sync       (rx_sync),
    .pll_powerdown (pll_powerdown),
    .xcvr_rst      (xcvr_rst),
    .tx_en         (tx_en),
    .link_up       (link_up),
    .state         (state),
    .retry_cnt     (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [14:0] vec;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_eval = 0;
  int   n_fail = 0;

  // Expected snapshot {state, pd, xcvr_rst, tx_en, link_up, retry_cnt}.
  function automatic logic [14:0] mk(input link_state_t s, input int r);
    logic [3:0] o;
    logic [7:0] rv;
    rv = r[7:0];
    case (s)
      LS_PD:        o = 4'b1100;
      LS_PLL_WAIT:  o = 4'b0100;
      LS_XCVR_WAIT: o = 4'b0000;
      LS_SYNC_WAIT: o = 4'b0010;
      LS_LINK_UP:   o = 4'b0011;
      default:      o = 4'b1100;
    endcase
    return {s, o, rv};
  endfunction

  function automatic logic [14:0] obs();
    return {state, pll_powerdown, xcvr_rst, tx_en, link_up, retry_cnt};
  endfunction

  // Advance n rising edges and sample 1 time unit later.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; force_down = 1'b0; pll_locked = 1'b0; pll_cal_busy = 1'b0;
    xcvr_tx_rdy = 1'b0; xcvr_rx_rdy = 1'b0; rx_sync = 1'b0;
    sb.push_back('{name: "reset_values", vec: mk(LS_PD, 0)});
    tick(3);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    sb.push_back('{name: "nom_pd_window", vec: mk(LS_PD, 0)});
    tick(3);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    sb.push_back('{name: "nom_pd_release", vec: mk(LS_PLL_WAIT, 0)});
    tick(1);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    tick(5);
    pll_locked = 1'b1;
    sb.push_back('{name: "nom_lock_sync_delay", vec: mk(LS_PLL_WAIT, 0)});
    tick(2);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    sb.push_back('{name: "nom_xcvr_rst_release", vec: mk(LS_XCVR_WAIT, 0)});
    tick(1);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    tick(7);
    xcvr_tx_rdy = 1'b1; xcvr_rx_rdy = 1'b1;
    sb.push_back('{name: "nom_rdy_sync_delay", vec: mk(LS_XCVR_WAIT, 0)});
    tick(2);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    sb.push_back('{name: "nom_sync_wait", vec: mk(LS_SYNC_WAIT, 0)});
    tick(1);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    tick(7);
    rx_sync = 1'b1;
    sb.push_back('{name: "nom_hold_edge9", vec: mk(LS_SYNC_WAIT, 0)});
    tick(9);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    sb.push_back('{name: "nom_link_up_edge10", vec: mk(LS_LINK_UP, 0)});
    tick(1);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
  endtask

  task automatic test_sync_glitch();
    // Three-cycle dropout in LINK_UP is filtered.
    rx_sync = 1'b0;
    tick(3);
    rx_sync = 1'b1;
    sb.push_back('{name: "loss3_mid", vec: mk(LS_LINK_UP, 0)});
    tick(2);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    sb.push_back('{name: "loss3_after", vec: mk(LS_LINK_UP, 0)});
    tick(2);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    // Four-cycle dropout falls back to SYNC_WAIT.
    rx_sync = 1'b0;
    tick(4);
    rx_sync = 1'b1;
    sb.push_back('{name: "loss4_third", vec: mk(LS_LINK_UP, 0)});
    tick(1);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    sb.push_back('{name: "loss4_to_sync_wait", vec: mk(LS_SYNC_WAIT, 0)});
    tick(1);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    // In SYNC_WAIT: high 7, low 1, high 8.
    rx_sync = 1'b0;
    tick(4);
    rx_sync = 1'b1;
    tick(7);
    rx_sync = 1'b0;
    tick(1);
    rx_sync = 1'b1;
    sb.push_back('{name: "glitch_first_run", vec: mk(LS_SYNC_WAIT, 0)});
    tick(1);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    sb.push_back('{name: "glitch_run2_seven", vec: mk(LS_SYNC_WAIT, 0)});
    tick(8);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    sb.push_back('{name: "glitch_run2_up", vec: mk(LS_LINK_UP, 0)});
    tick(1);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
  endtask

  task automatic test_lock_loss();
    // rx_sync loss is timed to hit the filter on the same edge the PLL loss is seen.
    rx_sync = 1'b0;
    tick(3);
    pll_locked = 1'b0;
    sb.push_back('{name: "lockloss_sync_delay", vec: mk(LS_LINK_UP, 0)});
    tick(2);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    sb.push_back('{name: "lockloss_retry", vec: mk(LS_PD, 1)});
    tick(1);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    pll_locked = 1'b1; rx_sync = 1'b1;
    sb.push_back('{name: "rebringup_link_up", vec: mk(LS_LINK_UP, 1)});
    tick(14);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
  endtask

  task automatic test_force_down();
    force_down = 1'b1;
    sb.push_back('{name: "force_enter_pd", vec: mk(LS_PD, 1)});
    tick(1);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    sb.push_back('{name: "force_hold_pd", vec: mk(LS_PD, 1)});
    tick(19);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    force_down = 1'b0;
    sb.push_back('{name: "force_release_window", vec: mk(LS_PD, 1)});
    tick(3);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    sb.push_back('{name: "force_release_pll_wait", vec: mk(LS_PLL_WAIT, 1)});
    tick(1);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
  endtask

  task automatic test_retry_then_reset();
    // TX ready drops just as the sequence reaches SYNC_WAIT.
    xcvr_tx_rdy = 1'b0;
    sb.push_back('{name: "rdy_loss_retry", vec: mk(LS_PD, 2)});
    tick(3);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    sb.push_back('{name: "xcvr_timeout_last", vec: mk(LS_XCVR_WAIT, 2)});
    tick(36);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    sb.push_back('{name: "xcvr_timeout_retry", vec: mk(LS_PD, 3)});
    tick(1);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    xcvr_tx_rdy = 1'b1;
    sb.push_back('{name: "sync_wait_retry3", vec: mk(LS_SYNC_WAIT, 3)});
    tick(8);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    rst = 1'b1;
    sb.push_back('{name: "mid_rst_values", vec: mk(LS_PD, 0)});
    tick(1);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
  endtask

  task automatic test_pll_timeout();
    int r;
    pll_locked = 1'b0;
    tick(2);
    rst = 1'b0;
    sb.push_back('{name: "pllto_first_wait", vec: mk(LS_PLL_WAIT, 0)});
    tick(4);
    e = sb.pop_front(); n_eval++;
    if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    for (int n = 1; n <= 300; n++) begin
      r = (n - 1 > 255) ? 255 : n - 1;
      sb.push_back('{name: $sformatf("pllto_wait_%0d", n), vec: mk(LS_PLL_WAIT, r)});
      tick((n == 1) ? 31 : 35);
      e = sb.pop_front(); n_eval++;
      if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
      r = (n > 255) ? 255 : n;
      sb.push_back('{name: $sformatf("pllto_retry_%0d", n), vec: mk(LS_PD, r)});
      tick(1);
      e = sb.pop_front(); n_eval++;
      if (obs() !== e.vec) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_sync_glitch();
    test_lock_loss();
    test_force_down();
    test_retry_then_reset();
    test_pll_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
